// File: rtl/card_shoe_if.sv
// Handshake bundle between a deal requester and the card_shoe card source.
interface card_shoe_if #(
  parameter int LEFT_W = 9
);
  logic              deal_req;
  logic              reshuffle;
  logic [3:0]        card;
  logic              card_valid;
  logic              busy;
  logic              shoe_empty;
  logic [LEFT_W-1:0] cards_left;

  modport master (
    output deal_req, reshuffle,
    input  card, card_valid, busy, shoe_empty, cards_left
  );

  modport slave (
    input  deal_req, reshuffle,
    output card, card_valid, busy, shoe_empty, cards_left
  );
endinterface

// File: rtl/card_shoe.sv
// Finite shoe of DECKS decks dealing one rank per request via a free-running rank counter.
// Optional macro AUTO_RESHUFFLE_EN: an empty-shoe request refills the shoe instead of flagging shoe_empty.
module card_shoe #(
  parameter int DECKS  = 1,
  parameter int LEFT_W = 9
) (
  input logic       clock,
  input logic       resetb,
  card_shoe_if.slave bus
);
  localparam int                UW   = $clog2(4 * DECKS + 1);
  localparam logic [UW-1:0]     MAX  = UW'(4 * DECKS);
  localparam logic [LEFT_W-1:0] FULL = LEFT_W'(52 * DECKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        rank_ctr_r, cand_r, card_r;
  logic [UW-1:0]     used_r [1:13];
  logic [LEFT_W-1:0] left_r;
  logic              empty_r;
  logic              load_s, step_s, deal_s, set_empty_s, refill_s;
  logic              avail_s, no_left_s;

  function automatic logic [3:0] next_rank(input logic [3:0] r);
    return (r == 4'd13) ? 4'd1 : r + 4'd1;
  endfunction

  assign avail_s   = (used_r[cand_r] < MAX);
  assign no_left_s = (left_r == {LEFT_W{1'b0}});

  assign bus.card       = card_r;
  assign bus.card_valid = (state_r == DEAL);
  assign bus.busy       = (state_r != IDLE);
  assign bus.shoe_empty = empty_r;
  assign bus.cards_left = left_r;

  // FSM state register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath strobes; reshuffle overrides everything
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    deal_s      = 1'b0;
    set_empty_s = 1'b0;
    refill_s    = 1'b0;
    if (bus.reshuffle) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.deal_req) begin
            if (!no_left_s) begin
              load_s  = 1'b1;
              state_s = SEARCH;
            end else begin
`ifdef AUTO_RESHUFFLE_EN
              refill_s = 1'b1;
              load_s   = 1'b1;
              state_s  = SEARCH;
`else
              set_empty_s = 1'b1;
`endif
            end
          end else begin
            state_s = IDLE;
          end
        end
        SEARCH: begin
          // cards_left>0 on entry guarantees some rank is below MAX within 13 steps
          if (avail_s) begin
            deal_s  = 1'b1;
            state_s = DEAL;
          end else begin
            step_s = 1'b1;
          end
        end
        DEAL:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Rank counter, candidate, usage tracking and dealt card
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rank_ctr_r <= 4'd1;
      cand_r     <= 4'd1;
      card_r     <= 4'd0;
      left_r     <= FULL;
      empty_r    <= 1'b0;
      for (int i = 1; i <= 13; i++) used_r[i] <= {UW{1'b0}};
    end else begin
      rank_ctr_r <= next_rank(rank_ctr_r);
      if (bus.reshuffle || refill_s) begin
        for (int i = 1; i <= 13; i++) used_r[i] <= {UW{1'b0}};
        left_r <= FULL;
      end
      if (bus.reshuffle) begin
        empty_r <= 1'b0;
        card_r  <= 4'd0;
      end else begin
        if (set_empty_s) begin
          empty_r <= 1'b1;
        end
        if (load_s) begin
          cand_r <= rank_ctr_r;
        end else if (step_s) begin
          cand_r <= next_rank(cand_r);
        end
        if (deal_s) begin
          card_r         <= cand_r;
          used_r[cand_r] <= used_r[cand_r] + {{(UW-1){1'b0}}, 1'b1};
          left_r         <= left_r - {{(LEFT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end
endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
Card source for the baccarat datapath, the producer side of the hand-scoring logic. On each deal request it returns one card rank (1..13: 1=Ace, 11..13=J/Q/K) drawn from a finite shoe of DECKS standard decks. Per-rank usage is tracked so no rank is dealt more than 4*DECKS times. Pseudo-randomness comes from a free-running rank counter sampled at request time. Dealt cards feed the hand card registers consumed by the scorer.

Parameters:
DECKS, 1, number of 52-card decks in the shoe; legal 1..8; per-rank limit MAX = 4*DECKS
LEFT_W, 9, width of cards_left; must satisfy 2^LEFT_W > 52*DECKS

Ports:
clock  input  1  single system clock, rising edge
resetb  input  1  asynchronous active-low reset
deal_req  input  1  level request for one card; sampled only in IDLE
reshuffle  input  1  synchronous: empty the used-card tracking, refill shoe
card  output  4  last dealt rank 1..13; 0 = none dealt since reset/reshuffle
card_valid  output  1  one-cycle pulse, card updated this cycle
busy  output  1  high in SEARCH or DEAL
shoe_empty  output  1  sticky: a request arrived with cards_left==0
cards_left  output  LEFT_W  undealt cards remaining

Behaviour:
- Reset (async, resetb=0): state=IDLE, rank_ctr=1, all 13 used counters=0, card=0, card_valid=0, busy=0, shoe_empty=0, cards_left=52*DECKS.
- rank_ctr: free-running every clock in all states, 1..13, wraps 13->1.
- Used counters: 13 x ceil(log2(MAX+1)) bits. A rank is available when used[r] < MAX.
- FSM states: IDLE, SEARCH, DEAL.
- IDLE: deal_req=1 and cards_left>0 -> cand<=rank_ctr, go SEARCH. deal_req=1 and cards_left==0 -> shoe_empty<=1, stay IDLE, no card_valid.
- SEARCH: used[cand]<MAX -> card<=cand, used[cand]++, cards_left--, go DEAL. Otherwise cand<=cand+1 (13 wraps to 1), stay SEARCH.
- SEARCH terminates within 13 cycles, guaranteed because cards_left>0 at entry.
- DEAL: card_valid=1 for exactly this cycle, then return to IDLE.
- Latency: deal_req sampled in IDLE -> card_valid 2 cycles later best case, 14 cycles worst case.
- deal_req held high deals one card per IDLE visit, i.e. back-to-back with one IDLE cycle between deals.
- card holds its value between deals. card_valid=0 outside DEAL.
- reshuffle=1 has priority over everything except reset, in any state:
  - next edge: used counters cleared, cards_left=52*DECKS, shoe_empty=0, card=0, state=IDLE.
  - An in-flight SEARCH is aborted with no card_valid. A deal landing in the same cycle is discarded.
  - rank_ctr is unaffected.
- Reset mid-operation: immediate return to reset values. No partial deal is visible.
- Invariant: cards_left == 52*DECKS - sum(used[r]) at all times.

Optional Feature:
Macro AUTO_RESHUFFLE_EN.
- Defined: a request in IDLE with cards_left==0 performs an implicit reshuffle (counters cleared, cards_left=52*DECKS) and enters SEARCH the same cycle with cand=rank_ctr. shoe_empty is never set.
- Undefined: behaviour exactly as specified above (shoe_empty set, request ignored).

Test Plan:
- Reset check: pulse resetb low mid-SEARCH -> card=0, card_valid=0, busy=0, shoe_empty=0, cards_left=52 immediately, asynchronously.
- Deterministic first deal: release reset; assert deal_req on the 5th rising edge after release, when rank_ctr=5 -> card=5 with card_valid on edge 7, cards_left=51.
- Full shoe (DECKS=1): hold deal_req for 52 deals -> each rank 1..13 seen exactly 4 times, cards_left=0. The 53rd request -> shoe_empty=1, no card_valid.
- Rank skip: exhaust rank 13 (4 deals), then request while rank_ctr=13 -> card=1 after one extra SEARCH cycle (wrap).
- Reshuffle abort: exhaust ranks 7..13, request at rank_ctr=7, assert reshuffle 2 cycles later -> no card_valid, cards_left=52, card=0, IDLE.
- With AUTO_RESHUFFLE_EN: empty shoe, request -> card_valid with a valid card, cards_left=51, shoe_empty stays 0.
